complex_nr_mult_pipe: RTL and testbench
=======================================

COMPLEX_NR_MULT_PIPE -- requirements
Module: complex_nr_mult_pipe

Interface
REQ-001 Parameter DATA_W, default 8, operand component width, signed two's complement, legal range 2..16.
REQ-002 Parameter FIFO_DEPTH, default 4, result buffer entries, power of two, legal range 2..16.
REQ-003 Localparam RES_W = 2*DATA_W+1, result component width, signed.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rstn_i  in  1  asynchronous active-low reset.
REQ-006 sw_rst_i  in  1  synchronous soft reset, active high.
REQ-007 op_val_i  in  1  operand set valid.
REQ-008 op_rdy_o  out  1  block can accept an operand set.
REQ-009 op_1_re_i, op_1_im_i, op_2_re_i, op_2_im_i  in  DATA_W each  operand components (a, b, c, d).
REQ-010 conj_i  in  1  mode, sampled with operands: 0 = op1*op2, 1 = op1*conj(op2).
REQ-011 res_val_o  out  1  result valid.
REQ-012 res_rdy_i  in  1  consumer ready.
REQ-013 res_re_o, res_im_o  out  RES_W each  result real and imaginary parts.

Function
REQ-014 Operand transfer on a rising edge with op_val_i=1 and op_rdy_o=1; result transfer on a rising edge with res_val_o=1 and res_rdy_i=1.
REQ-015 conj_i=0: re = a*c - b*d, im = a*d + b*c; conj_i=1: re = a*c + b*d, im = b*c - a*d.
REQ-016 All arithmetic full precision, signed, sign-extended to RES_W; no saturation, no truncation.
REQ-017 Pipeline, 3 stages: S1 registers operands and mode; S2 registers four DATA_W x DATA_W signed products; S3 registers add/sub result and writes it into the FIFO.
REQ-018 Pipeline never stalls; each accepted operand set advances one stage per cycle regardless of res_rdy_i.
REQ-019 Latency: operand accepted at edge N -> res_val_o=1 after edge N+3 when the FIFO was empty and no pop intervened.
REQ-020 Results leave in acceptance order.
REQ-021 Credit counter cnt, range 0..FIFO_DEPTH, counts S1..S3 in-flight plus FIFO-resident results.
REQ-022 cnt +1 on operand transfer only, -1 on result transfer only, unchanged on both together or neither.
REQ-023 op_rdy_o = (cnt < FIFO_DEPTH), decoded from registered cnt; FIFO overflow is therefore impossible.
REQ-024 FIFO: circular buffer, read/write pointers wrap modulo FIFO_DEPTH; simultaneous push and pop at any fill level, including full and empty, are both performed.
REQ-025 res_val_o = FIFO not empty; res_re_o/res_im_o show the FIFO head, and 0 when empty.
REQ-026 op_val_i=1 with op_rdy_o=0: operands ignored and held by the producer; no state change.
REQ-027 res_rdy_i=1 with res_val_o=0: no effect.

Reset
REQ-028 rstn_i=0 clears immediately, asynchronously: stage valids, products, FIFO pointers, cnt; op_rdy_o=1, res_val_o=0, res_re_o=0, res_im_o=0.
REQ-029 sw_rst_i=1 at an edge: same clear, synchronously; it overrides any concurrent operand or result transfer.
REQ-030 Reset mid-operation discards all in-flight and buffered results; none appear after release.
REQ-031 First operand transfer possible at the first rising edge after rstn_i deasserts.

Verification
REQ-032 DATA_W=8; a=2, b=3, c=4, d=2, conj_i=0, res_rdy_i=1 -> res_re_o=2, res_im_o=16, 3 cycles after acceptance.
REQ-033 Same operands, conj_i=1 -> res_re_o=14, res_im_o=8.
REQ-034 a=b=c=d=-128, conj_i=1 -> res_re_o=32768 (17-bit signed), res_im_o=0; conj_i=0 -> re=0, im=32768.
REQ-035 res_rdy_i=0, FIFO_DEPTH=4, back-to-back ops 1..5 -> op_rdy_o=0 after the 4th acceptance, 5th held; raise res_rdy_i -> four results in order, then 5th accepted.
REQ-036 Continuous streaming, op_val_i=1 and res_rdy_i=1 for 20 cycles -> one result per cycle, cnt stable, op_rdy_o never drops.
REQ-037 sw_rst_i pulse with 2 results in flight and 2 buffered -> next cycle res_val_o=0, op_rdy_o=1; no stale results follow. Repeat with rstn_i -> same.

Source files
------------

// File: rtl/complex_nr_mult_pipe.sv
// Pipelined complex multiplier (op1*op2 or op1*conj(op2)) with a credit-managed
// result FIFO: the credit counter covers in-flight stages plus buffered results.
module complex_nr_mult_pipe #(
  parameter  int DATA_W     = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int RES_W      = 2*DATA_W+1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              sw_rst_i,
  input  logic              op_val_i,
  output logic              op_rdy_o,
  input  logic [DATA_W-1:0] op_1_re_i,
  input  logic [DATA_W-1:0] op_1_im_i,
  input  logic [DATA_W-1:0] op_2_re_i,
  input  logic [DATA_W-1:0] op_2_im_i,
  input  logic              conj_i,
  output logic              res_val_o,
  input  logic              res_rdy_i,
  output logic [RES_W-1:0]  res_re_o,
  output logic [RES_W-1:0]  res_im_o
);
  localparam int PW = 2*DATA_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  typedef struct packed {
    logic signed [DATA_W-1:0] a, b, c, d;
    logic                     conj;
  } op_t;

  typedef struct packed {
    logic signed [PW-1:0] ac, bd, ad, bc;
    logic                 conj;
  } prod_t;

  typedef struct packed {
    logic signed [RES_W-1:0] re, im;
  } res_t;

  op_t   op_q, op_d;
  prod_t prod_q, prod_d;
  res_t  res_q, res_d, head;
  res_t  mem_q [FIFO_DEPTH];

  logic [2:0]    vld_pipe_q, vld_pipe_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fill_q, fill_d, cnt_q, cnt_d;
  logic          op_fire, res_fire, push;

  logic signed [PW-1:0]    a_x, b_x, c_x, d_x;
  logic signed [RES_W-1:0] ac_x, bd_x, ad_x, bc_x;

  assign op_rdy_o  = cnt_q < CW'(FIFO_DEPTH);
  assign res_val_o = fill_q != '0;
  assign op_fire   = op_val_i & op_rdy_o;
  assign res_fire  = res_val_o & res_rdy_i;
  assign push      = vld_pipe_q[2];

  // Widen operands before multiplying so the full signed product is kept.
  assign a_x = {{DATA_W{op_q.a[DATA_W-1]}}, op_q.a};
  assign b_x = {{DATA_W{op_q.b[DATA_W-1]}}, op_q.b};
  assign c_x = {{DATA_W{op_q.c[DATA_W-1]}}, op_q.c};
  assign d_x = {{DATA_W{op_q.d[DATA_W-1]}}, op_q.d};

  assign ac_x = {prod_q.ac[PW-1], prod_q.ac};
  assign bd_x = {prod_q.bd[PW-1], prod_q.bd};
  assign ad_x = {prod_q.ad[PW-1], prod_q.ad};
  assign bc_x = {prod_q.bc[PW-1], prod_q.bc};

  assign head     = mem_q[rd_ptr_q];
  assign res_re_o = res_val_o ? head.re : '0;
  assign res_im_o = res_val_o ? head.im : '0;

  always_comb begin
    op_d.a    = op_1_re_i;
    op_d.b    = op_1_im_i;
    op_d.c    = op_2_re_i;
    op_d.d    = op_2_im_i;
    op_d.conj = conj_i;

    prod_d.ac   = a_x * c_x;
    prod_d.bd   = b_x * d_x;
    prod_d.ad   = a_x * d_x;
    prod_d.bc   = b_x * c_x;
    prod_d.conj = op_q.conj;

    res_d.re = prod_q.conj ? ac_x + bd_x : ac_x - bd_x;
    res_d.im = prod_q.conj ? bc_x - ad_x : ad_x + bc_x;

    vld_pipe_d = {vld_pipe_q[1:0], op_fire};
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(res_fire);

    cnt_d = cnt_q;
    if (op_fire && !res_fire)      cnt_d = cnt_q + CW'(1);
    else if (!op_fire && res_fire) cnt_d = cnt_q - CW'(1);

    fill_d = fill_q;
    if (push && !res_fire)      fill_d = fill_q + CW'(1);
    else if (!push && res_fire) fill_d = fill_q - CW'(1);

    // Soft reset wins over any transfer happening on the same edge.
    if (sw_rst_i) begin
      op_d       = '0;
      prod_d     = '0;
      res_d      = '0;
      vld_pipe_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      fill_d     = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      op_q       <= '0;
      prod_q     <= '0;
      res_q      <= '0;
      vld_pipe_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      fill_q     <= '0;
    end else begin
      op_q       <= op_d;
      prod_q     <= prod_d;
      res_q      <= res_d;
      vld_pipe_q <= vld_pipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
    end
  end

  // Storage needs no reset: visibility is governed by fill_q alone.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= res_q;
  end

endmodule

// File: tb/tb_complex_nr_mult_pipe.sv
// Directed bench: vector table for arithmetic, plus hand sequences for
// backpressure, streaming throughput and soft/hard reset discard.
module tb_complex_nr_mult_pipe;
  localparam int DW = 8;
  localparam int RW = 2*DW+1;

  logic clk = 1'b0;
  logic rstn, sw_rst, op_val, conj, res_rdy;
  logic [DW-1:0] a, b, c, d;
  logic op_rdy, res_val, op_rdy8, res_val8;
  logic [RW-1:0] re, im, re8, im8;

  always #5 clk = ~clk;

  complex_nr_mult_pipe #(.DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rstn_i(rstn), .sw_rst_i(sw_rst),
    .op_val_i(op_val), .op_rdy_o(op_rdy),
    .op_1_re_i(a), .op_1_im_i(b), .op_2_re_i(c), .op_2_im_i(d),
    .conj_i(conj), .res_val_o(res_val), .res_rdy_i(res_rdy),
    .res_re_o(re), .res_im_o(im));

  // Deeper instance so a 3-stage pipe plus one buffered result streams freely.
  complex_nr_mult_pipe #(.DATA_W(DW), .FIFO_DEPTH(8)) dut8 (
    .clk_i(clk), .rstn_i(rstn), .sw_rst_i(sw_rst),
    .op_val_i(op_val), .op_rdy_o(op_rdy8),
    .op_1_re_i(a), .op_1_im_i(b), .op_2_re_i(c), .op_2_im_i(d),
    .conj_i(conj), .res_val_o(res_val8), .res_rdy_i(res_rdy),
    .res_re_o(re8), .res_im_o(im8));

  typedef struct {
    int a, b, c, d;
    bit cj;
    int re, im;
  } vec_t;

  vec_t vt[9];
  int n_vec = 0;
  int n_err = 0;
  int nxt, last, acc;
  int rxq[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    sw_rst  = 1'b0;
    op_val  = 1'b0;
    res_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // One clock: records transfers seen before the edge, advances the op sequence.
  task automatic tick();
    bit fo, fr;
    fo = op_val && op_rdy;
    fr = res_val && res_rdy;
    if (fr) rxq.push_back($signed(re));
    @(posedge clk); #1;
    if (fo) begin
      acc++;
      nxt++;
      if (nxt > last) op_val = 1'b0;
      else a = DW'(nxt);
    end
  endtask

  task automatic start_seq(input int first, input int lst);
    nxt = first; last = lst; acc = 0;
    a = DW'(first); b = '0; c = DW'(1); d = '0; conj = 1'b0;
    op_val = 1'b1;
    rxq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{2, 3, 4, 2, 1'b0, 2, 16};
    vt[1] = '{2, 3, 4, 2, 1'b1, 14, 8};
    vt[2] = '{-128, -128, -128, -128, 1'b1, 32768, 0};
    vt[3] = '{-128, -128, -128, -128, 1'b0, 0, 32768};
    vt[4] = '{127, -128, 127, -128, 1'b0, -255, -32512};
    vt[5] = '{127, 127, 127, 127, 1'b1, 32258, 0};
    vt[6] = '{-1, 0, 0, -1, 1'b0, 0, 1};
    vt[7] = '{5, -7, -3, 9, 1'b1, -78, -24};
    vt[8] = '{5, -7, -3, 9, 1'b0, 48, 66};

    rstn = 1'b1; sw_rst = 1'b0; op_val = 1'b0; res_rdy = 1'b0; conj = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    #2 rstn = 1'b0;
    #1;
    chk("rst_op_rdy", op_rdy, 1);
    chk("rst_res_val", res_val, 0);
    chk("rst_re", re, 0);
    chk("rst_im", im, 0);
    do_reset();

    // Arithmetic table; first vector lands on the first edge after release.
    for (int i = 0; i < 9; i++) begin
      a = DW'(vt[i].a); b = DW'(vt[i].b); c = DW'(vt[i].c); d = DW'(vt[i].d);
      conj = vt[i].cj; op_val = 1'b1; res_rdy = 1'b1;
      chk("vec_op_rdy", op_rdy, 1);
      @(posedge clk); #1 op_val = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("vec_lat2_val", res_val, 0);
      @(posedge clk); #1;
      chk("vec_lat3_val", res_val, 1);
      chk("vec_re", $signed(re), vt[i].re);
      chk("vec_im", $signed(im), vt[i].im);
      @(posedge clk); #1;
      chk("vec_popped", res_val, 0);
    end

    // Backpressure with depth 4: 4 accepted, 5th held until a pop frees a credit.
    do_reset();
    start_seq(1, 5);
    for (int i = 0; i < 10 && acc < 4; i++) tick();
    chk("bp_acc4", acc, 4);
    chk("bp_full_rdy", op_rdy, 0);
    repeat (3) tick();
    chk("bp_held5", acc, 4);
    chk("bp_head_val", res_val, 1);
    chk("bp_head_re", $signed(re), 1);
    res_rdy = 1'b1;
    for (int i = 0; i < 20 && rxq.size() < 5; i++) tick();
    chk("bp_rx_count", rxq.size(), 5);
    chk("bp_acc5", acc, 5);
    for (int k = 0; k < rxq.size(); k++) chk("bp_order", rxq[k], k+1);

    // Streaming on the deeper instance: one result per cycle, never stalled.
    do_reset();
    begin
      int got8, n8;
      got8 = 0; n8 = 1;
      a = DW'(1); b = '0; c = DW'(1); d = '0; conj = 1'b0;
      op_val = 1'b1; res_rdy = 1'b1;
      for (int i = 0; i < 24; i++) begin
        chk("stream_rdy", op_rdy8, 1);
        if (i >= 4) chk("stream_val", res_val8, 1);
        if (res_val8) begin
          chk("stream_re", $signed(re8), got8+1);
          chk("stream_im", $signed(im8), 0);
          got8++;
        end
        @(posedge clk); #1;
        n8++;
        a = DW'(n8);
      end
      op_val = 1'b0;
      chk("stream_count", got8, 20);
    end

    // Soft reset with two results in the pipe and two buffered.
    do_reset();
    start_seq(11, 14);
    for (int i = 0; i < 10 && acc < 4; i++) tick();
    tick();
    chk("sw_pre_val", res_val, 1);
    sw_rst = 1'b1; op_val = 1'b1; res_rdy = 1'b1;
    @(posedge clk); #1;
    sw_rst = 1'b0; op_val = 1'b0;
    chk("sw_res_val", res_val, 0);
    chk("sw_op_rdy", op_rdy, 1);
    chk("sw_re", re, 0);
    begin
      int stale;
      stale = 0;
      repeat (8) begin @(posedge clk); #1; if (res_val) stale++; end
      chk("sw_stale", stale, 0);
    end
    res_rdy = 1'b0;
    start_seq(1, 3);
    for (int i = 0; i < 10 && acc < 3; i++) tick();
    chk("sw_cnt_acc", acc, 3);
    chk("sw_cnt_rdy", op_rdy, 1);

    // Same scenario, asynchronous hard reset mid-cycle.
    do_reset();
    start_seq(11, 14);
    for (int i = 0; i < 10 && acc < 4; i++) tick();
    tick();
    #2 rstn = 1'b0;
    #1;
    chk("hr_res_val", res_val, 0);
    chk("hr_op_rdy", op_rdy, 1);
    chk("hr_re", re, 0);
    chk("hr_im", im, 0);
    @(negedge clk) rstn = 1'b1;
    res_rdy = 1'b1;
    begin
      int stale;
      stale = 0;
      repeat (8) begin @(posedge clk); #1; if (res_val) stale++; end
      chk("hr_stale", stale, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
